// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from combinational memory into a 2-entry queue.
// Optional static backward-taken branch prediction is enabled by defining FETCH_BRANCH_PREDICT_EN.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter logic [15:0] PC_LIMIT = 16'd10
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc_out,
  input  logic [15:0] instr_in,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_pred_taken,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  logic [15:0] pc;
  logic [1:0]  count;
  logic        halted_q;
  logic [15:0] q_instr [2];
  logic [15:0] q_pc    [2];
  logic        q_pred  [2];

  logic        pop;
  logic        fetch;
  logic        fetch_pred;
  logic [15:0] next_pc;

  assign pop   = (count != 2'd0) && id_ready;
  assign fetch = !halted_q && !redirect_valid && ((count != 2'd2) || pop);

  always_comb begin
    fetch_pred = 1'b0;
    next_pc    = pc + 16'd1;
`ifdef FETCH_BRANCH_PREDICT_EN
    // Backward bz (negative offset) is predicted taken; forward bz falls through.
    if (instr_in[15:12] == 4'b1100 && instr_in[5]) begin
      fetch_pred = 1'b1;
      next_pc    = pc + 16'd1 + {{10{instr_in[5]}}, instr_in[5:0]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      count    <= 2'd0;
      halted_q <= (RESET_PC > PC_LIMIT);
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= 16'd0;
        q_pc[i]    <= 16'd0;
        q_pred[i]  <= 1'b0;
      end
    end else if (redirect_valid) begin
      count    <= 2'd0;
      pc       <= redirect_pc;
      halted_q <= (redirect_pc > PC_LIMIT);
    end else begin
      case ({pop, fetch})
        2'b01: begin
          q_instr[count[0]] <= instr_in;
          q_pc[count[0]]    <= pc;
          q_pred[count[0]]  <= fetch_pred;
          count             <= count + 2'd1;
        end
        2'b10: begin
          q_instr[0] <= q_instr[1];
          q_pc[0]    <= q_pc[1];
          q_pred[0]  <= q_pred[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves; the new word lands behind whatever remains.
          if (count == 2'd2) begin
            q_instr[0] <= q_instr[1];
            q_pc[0]    <= q_pc[1];
            q_pred[0]  <= q_pred[1];
            q_instr[1] <= instr_in;
            q_pc[1]    <= pc;
            q_pred[1]  <= fetch_pred;
          end else begin
            q_instr[0] <= instr_in;
            q_pc[0]    <= pc;
            q_pred[0]  <= fetch_pred;
          end
        end
        default: ;
      endcase
      if (fetch) begin
        pc       <= next_pc;
        halted_q <= (next_pc > PC_LIMIT);
      end
    end
  end

  assign pc_out        = pc;
  assign halted        = halted_q;
  assign if_valid      = (count != 2'd0);
  assign if_instr      = if_valid ? q_instr[0] : 16'd0;
  assign if_pc         = if_valid ? q_pc[0]    : 16'd0;
  assign if_pred_taken = if_valid ? q_pred[0]  : 1'b0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized run against a queue model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'd0;
  logic        halted;

  localparam logic [15:0] LIMIT = 16'd10;

  int checks = 0;
  int failures = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .instr_in(instr_in),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory contents (combinational read)
  logic [15:0] mem [64];
  always_comb instr_in = mem[pc_out[5:0]];

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        pred;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_pc;
  logic        m_halted;

  function automatic logic pred_taken(input logic [15:0] w);
`ifdef FETCH_BRANCH_PREDICT_EN
    return (w[15:12] == 4'b1100) && w[5];
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock, updating the reference model from the inputs seen at this edge.
  task automatic step();
    ent_t e;
    logic p, f;
    int   off;
    if (rst) begin
      m_q.delete();
      m_pc     = 16'd0;
      m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc     = redirect_pc;
      m_halted = (redirect_pc > LIMIT);
    end else begin
      p = (m_q.size() > 0) && id_ready;
      f = !m_halted && ((m_q.size() < 2) || p);
      if (p) void'(m_q.pop_front());
      if (f) begin
        e.instr = mem[m_pc[5:0]];
        e.pc    = m_pc;
        e.pred  = pred_taken(e.instr);
        m_q.push_back(e);
        off = e.pred ? int'($signed(e.instr[5:0])) : 0;
        m_pc = 16'((int'(m_pc) + 1 + off) & 32'hFFFF);
        m_halted = (m_pc > LIMIT);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit allow_bz);
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'($urandom);
      if (!allow_bz && mem[i][15:12] == 4'b1100) mem[i][15:12] = 4'b0000;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    id_ready = 1'b0;
    do_reset();
    checks++;
    if (pc_out !== 16'd0 || if_valid !== 1'b0 || if_instr !== 16'd0 || if_pc !== 16'd0 ||
        if_pred_taken !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset: pc_out=%0d valid=%b instr=%h if_pc=%0d pred=%b halted=%b, required 0/0/0/0/0/0",
               pc_out, if_valid, if_instr, if_pc, if_pred_taken, halted);
    end
  endtask

  task automatic test_stream();
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 16'(i) || if_instr !== mem[i]) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b if_pc=%0d instr=%h, required 1/%0d/%h",
                 i, if_valid, if_pc, if_instr, i, mem[i]);
      end
    end
    checks++;
    if (pc_out !== 16'd11 || halted !== 1'b1) begin
      failures++;
      $display("FAIL stream_halt: pc_out=%0d halted=%b, required 11/1", pc_out, halted);
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || pc_out !== 16'd11) begin
      failures++;
      $display("FAIL stream_drain: valid=%b pc_out=%0d, required 0/11", if_valid, pc_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    id_ready = 1'b0;
    step(); step(); step();
    checks++;
    if (pc_out !== 16'd2 || if_valid !== 1'b1 || if_pc !== 16'd0) begin
      failures++;
      $display("FAIL bp_full: pc_out=%0d valid=%b if_pc=%0d, required 2/1/0", pc_out, if_valid, if_pc);
    end
    id_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 16'(i)) begin
        failures++;
        $display("FAIL bp_release[%0d]: valid=%b if_pc=%0d, required 1/%0d", i, if_valid, if_pc, i);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    id_ready = 1'b1;
    step(); step(); step();
    id_ready = 1'b0;
    step();
    checks++;
    if (if_pc !== 16'd2 || pc_out !== 16'd4) begin
      failures++;
      $display("FAIL redir_setup: if_pc=%0d pc_out=%0d, required 2/4", if_pc, pc_out);
    end
    redirect_valid = 1'b1; redirect_pc = 16'd5;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || pc_out !== 16'd5) begin
      failures++;
      $display("FAIL redir_flush: valid=%b pc_out=%0d, required 0/5", if_valid, pc_out);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'd5 || if_instr !== mem[5]) begin
      failures++;
      $display("FAIL redir_first: valid=%b if_pc=%0d instr=%h, required 1/5/%h", if_valid, if_pc, if_instr, mem[5]);
    end
  endtask

  task automatic test_halt_redirect();
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (halted !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_state: halted=%b valid=%b, required 1/0", halted, if_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 16'd4;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || pc_out !== 16'd4 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume: halted=%b pc_out=%0d valid=%b, required 0/4/0", halted, pc_out, if_valid);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'd4) begin
      failures++;
      $display("FAIL halt_resume_head: valid=%b if_pc=%0d, required 1/4", if_valid, if_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 16'd12;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || pc_out !== 16'd12) begin
      failures++;
      $display("FAIL halt_beyond: halted=%b valid=%b pc_out=%0d, required 1/0/12", halted, if_valid, pc_out);
    end
  endtask

  task automatic test_reset_with_redirect();
    do_reset();
    id_ready = 1'b1;
    step(); step(); step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd7;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (pc_out !== 16'd0 || if_valid !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL rst_over_redirect: pc_out=%0d valid=%b halted=%b, required 0/0/0", pc_out, if_valid, halted);
    end
  endtask

`ifdef FETCH_BRANCH_PREDICT_EN
  task automatic test_predict();
    mem[10] = 16'b1100_0000_0011_1010;
    mem[4]  = 16'b1100_0000_0000_0010;
    do_reset();
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'd10;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (pc_out !== 16'd5 || if_pc !== 16'd10 || if_pred_taken !== 1'b1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL predict_back: pc_out=%0d if_pc=%0d pred=%b halted=%b, required 5/10/1/0",
               pc_out, if_pc, if_pred_taken, halted);
    end
    redirect_valid = 1'b1; redirect_pc = 16'd4;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (pc_out !== 16'd5 || if_pc !== 16'd4 || if_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL predict_fwd: pc_out=%0d if_pc=%0d pred=%b, required 5/4/0", pc_out, if_pc, if_pred_taken);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] e_instr, e_pc;
    logic        e_pred;
    fill_mem(1'b1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_ready       = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = 16'($urandom_range(14));
      rst            = ($urandom_range(99) == 0);
      step();
      e_instr = (m_q.size() > 0) ? m_q[0].instr : 16'd0;
      e_pc    = (m_q.size() > 0) ? m_q[0].pc    : 16'd0;
      e_pred  = (m_q.size() > 0) ? m_q[0].pred  : 1'b0;
      checks++;
      if (pc_out !== m_pc || halted !== m_halted || if_valid !== (m_q.size() > 0) ||
          if_instr !== e_instr || if_pc !== e_pc || if_pred_taken !== e_pred) begin
        failures++;
        $display("FAIL random[%0d]: pc_out=%0d halted=%b valid=%b instr=%h if_pc=%0d pred=%b, required %0d/%b/%b/%h/%0d/%b",
                 c, pc_out, halted, if_valid, if_instr, if_pc, if_pred_taken,
                 m_pc, m_halted, (m_q.size() > 0), e_instr, e_pc, e_pred);
      end
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    fill_mem(1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt_redirect();
    test_reset_with_redirect();
`ifdef FETCH_BRANCH_PREDICT_EN
    test_predict();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
